// File: rtl/qusim_axil_pkg.sv
// ---------------------------------------------------------------------------
// qusim_axil_pkg
// Shared types and constants for the qusim AXI4-Lite register-file slave.
//   axil_resp_t  : AXI response encoding (OKAY / SLVERR)
//   wr_state_t   : write-channel FSM states
//   rd_state_t   : read-channel FSM states
//   AXIL_DATA_W, AXIL_STRB_W, DECERR_RDATA : bus widths and the read value
//                  returned for undecoded addresses when decode errors are on
// ---------------------------------------------------------------------------
package qusim_axil_pkg;

    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = 4;

    localparam logic [AXIL_DATA_W-1:0] DECERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axil_resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/qusim_axil_wr_capture.sv
// ---------------------------------------------------------------------------
// qusim_axil_wr_capture
// Generic one-entry valid/ready capture buffer. Used once for the AW channel
// and once for the W channel so the two can arrive in either order.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   data, valid   incoming payload and its valid
//   ready         out: buffer empty and capture enabled
//   enable        allow capture this cycle (write FSM idle, out of reset)
//   clear         empty the buffer (asserted when the write commits)
//   full, q       buffer occupancy and held payload
// ---------------------------------------------------------------------------
module qusim_axil_wr_capture #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    input  logic             enable,
    input  logic             clear,
    output logic             full,
    output logic [WIDTH-1:0] q
);

    assign ready = enable & ~full;

    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            q    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (valid && ready) begin
            full <= 1'b1;
            q    <= data;
        end
    end

endmodule

// File: rtl/qusim_axil_regfile_slave.sv
// ---------------------------------------------------------------------------
// qusim_axil_regfile_slave
// AXI4-Lite slave register bank: NUM_REGS 32-bit RW registers at byte offset
// 4*i, exported on regs_o for the qusim datapath.
// Ports:
//   ACLK, ARESET          clock, asynchronous active-high reset
//   S_AXI_AW* / S_AXI_W*  write address / data channels (PROT ignored)
//   S_AXI_B*              write response channel
//   S_AXI_AR* / S_AXI_R*  read address / data channels (PROT ignored)
//   regs_o                register contents, reg i at [32i+31:32i]
// Configuration macro:
//   QUSIM_AXIL_DECERR_EN  defined  : out-of-range accesses get SLVERR, writes
//                                    dropped, reads return DECERR_RDATA
//                         undefined: out-of-range slots alias index mod
//                                    NUM_REGS, responses always OKAY
// ---------------------------------------------------------------------------
module qusim_axil_regfile_slave
    import qusim_axil_pkg::*;
#(
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                S_AXI_AWPROT,
    input  logic                      S_AXI_AWVALID,
    output logic                      S_AXI_AWREADY,
    input  logic [AXIL_DATA_W-1:0]    S_AXI_WDATA,
    input  logic [AXIL_STRB_W-1:0]    S_AXI_WSTRB,
    input  logic                      S_AXI_WVALID,
    output logic                      S_AXI_WREADY,
    output logic [1:0]                S_AXI_BRESP,
    output logic                      S_AXI_BVALID,
    input  logic                      S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                S_AXI_ARPROT,
    input  logic                      S_AXI_ARVALID,
    output logic                      S_AXI_ARREADY,
    output logic [AXIL_DATA_W-1:0]    S_AXI_RDATA,
    output logic [1:0]                S_AXI_RRESP,
    output logic                      S_AXI_RVALID,
    input  logic                      S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]    regs_o
);

`ifdef QUSIM_AXIL_DECERR_EN
    localparam bit DECERR_EN = 1'b1;
`else
    localparam bit DECERR_EN = 1'b0;
`endif

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int SEL_W = $clog2(NUM_REGS);
    localparam logic [IDX_W:0] NUM_REGS_CMP = (IDX_W+1)'(NUM_REGS);
    localparam int WBUF_W = AXIL_STRB_W + AXIL_DATA_W;

    logic [AXIL_DATA_W-1:0] regs [NUM_REGS];

    // READYs stay low until the first edge after reset release.
    logic init_done;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) init_done <= 1'b0;
        else        init_done <= 1'b1;
    end

    // ---------------------------------------------------------------- write
    wr_state_t wr_state, wr_state_next;
    logic      capture_en, commit;
    logic      aw_full, w_full, aw_hs, w_hs;
    logic [ADDR_WIDTH-1:0] aw_q;
    logic [WBUF_W-1:0]     w_q;

    qusim_axil_wr_capture #(.WIDTH(ADDR_WIDTH)) u_aw_capture (
        .clk    (ACLK),
        .rst    (ARESET),
        .data   (S_AXI_AWADDR),
        .valid  (S_AXI_AWVALID),
        .ready  (S_AXI_AWREADY),
        .enable (capture_en),
        .clear  (commit),
        .full   (aw_full),
        .q      (aw_q)
    );

    qusim_axil_wr_capture #(.WIDTH(WBUF_W)) u_w_capture (
        .clk    (ACLK),
        .rst    (ARESET),
        .data   ({S_AXI_WSTRB, S_AXI_WDATA}),
        .valid  (S_AXI_WVALID),
        .ready  (S_AXI_WREADY),
        .enable (capture_en),
        .clear  (commit),
        .full   (w_full),
        .q      (w_q)
    );

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) wr_state <= W_IDLE;
        else        wr_state <= wr_state_next;
    end

    // Enter W_COMMIT on the edge that completes the later of AW/W, so the
    // register update and BVALID land exactly one cycle after that edge.
    // NOTE: every always_comb assigns a default first so no path can leave a
    // signal unassigned and infer a latch.
    always_comb begin
        wr_state_next = wr_state;
        case (wr_state)
            W_IDLE:   if ((aw_full || aw_hs) && (w_full || w_hs))
                          wr_state_next = W_COMMIT;
            W_COMMIT: wr_state_next = W_RESP;
            W_RESP:   if (S_AXI_BREADY) wr_state_next = W_IDLE;
            default:  wr_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        capture_en   = init_done && (wr_state == W_IDLE);
        commit       = (wr_state == W_COMMIT);
        S_AXI_BVALID = (wr_state == W_RESP);
    end

    logic [IDX_W-1:0]       wr_idx;
    logic [SEL_W-1:0]       wr_sel;
    logic                   wr_in_range, wr_ok;
    logic [AXIL_DATA_W-1:0] wr_data;
    logic [AXIL_STRB_W-1:0] wr_strb;

    assign wr_idx      = aw_q[ADDR_WIDTH-1:2];
    assign wr_sel      = wr_idx[SEL_W-1:0];
    assign wr_in_range = ({1'b0, wr_idx} < NUM_REGS_CMP);
    assign wr_ok       = wr_in_range || !DECERR_EN;
    assign wr_data     = w_q[AXIL_DATA_W-1:0];
    assign wr_strb     = w_q[WBUF_W-1:AXIL_DATA_W];

    // NOTE: the register array is reset explicitly because software expects
    // zeros after reset; it is small flop storage, not a RAM macro.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit && wr_ok) begin
            for (int k = 0; k < AXIL_STRB_W; k++) begin
                if (wr_strb[k]) regs[wr_sel][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    axil_resp_t bresp_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)      bresp_q <= OKAY;
        else if (commit) bresp_q <= wr_ok ? OKAY : SLVERR;
    end

    assign S_AXI_BRESP = bresp_q;

    // ----------------------------------------------------------------- read
    rd_state_t rd_state, rd_state_next;
    logic      ar_hs;

    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) rd_state <= R_IDLE;
        else        rd_state <= rd_state_next;
    end

    always_comb begin
        rd_state_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_state_next = R_RESP;
            R_RESP:  if (S_AXI_RREADY) rd_state_next = R_IDLE;
            default: rd_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_ARREADY = init_done && (rd_state == R_IDLE);
        S_AXI_RVALID  = (rd_state == R_RESP);
    end

    logic [IDX_W-1:0] rd_idx;
    logic [SEL_W-1:0] rd_sel;
    logic             rd_in_range;

    assign rd_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign rd_sel      = rd_idx[SEL_W-1:0];
    assign rd_in_range = ({1'b0, rd_idx} < NUM_REGS_CMP);

    logic [AXIL_DATA_W-1:0] rdata_q;
    axil_resp_t             rresp_q;

    // Sampled at the AR edge, so a write committing on that same edge is not
    // yet visible: the read returns the pre-write value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rdata_q <= '0;
            rresp_q <= OKAY;
        end else if (ar_hs) begin
            if (DECERR_EN && !rd_in_range) begin
                rdata_q <= DECERR_RDATA;
                rresp_q <= SLVERR;
            end else begin
                rdata_q <= regs[rd_sel];
                rresp_q <= OKAY;
            end
        end
    end

    assign S_AXI_RDATA = rdata_q;
    assign S_AXI_RRESP = rresp_q;

    // --------------------------------------------------------------- export
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_export
        assign regs_o[32*i +: 32] = regs[i];
    end

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, aw_q[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_qusim_axil_regfile_slave.sv
// ---------------------------------------------------------------------------
// tb_qusim_axil_regfile_slave
// Directed bench for qusim_axil_regfile_slave. Stimulus tasks push expected
// B/R responses into queues; a negedge monitor pops and compares them on each
// completed handshake. Honours QUSIM_AXIL_DECERR_EN for out-of-range cases.
// ---------------------------------------------------------------------------
module tb_qusim_axil_regfile_slave;

    localparam int TIMEOUT = 50;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, wvalid, bready, arvalid, rready;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [127:0] regs_o;

    int checks = 0;
    int errors = 0;

    logic [1:0]  b_exp_q [$];
    logic [33:0] r_exp_q [$];

    always #5 clk = ~clk;

    qusim_axil_regfile_slave dut (
        .ACLK          (clk),
        .ARESET        (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .regs_o        (regs_o)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out after %0d cycles", name, TIMEOUT);
    endtask

    // Monitor: a handshake seen at a negedge completes on the following posedge.
    initial begin
        logic [1:0]  b_exp;
        logic [33:0] r_exp;
        forever begin
            @(negedge clk);
            if (!rst && bvalid && bready) begin
                if (b_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: got bresp %0h expected no response", bresp);
                end else begin
                    b_exp = b_exp_q.pop_front();
                    check("bresp", {126'b0, bresp}, {126'b0, b_exp});
                end
            end
            if (!rst && rvalid && rready) begin
                if (r_exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL r_unexpected: got rdata %0h expected no response", rdata);
                end else begin
                    r_exp = r_exp_q.pop_front();
                    check("rdata", {96'b0, rdata}, {96'b0, r_exp[31:0]});
                    check("rresp", {126'b0, rresp}, {126'b0, r_exp[33:32]});
                end
            end
        end
    end

    task automatic aw_send(input logic [5:0] addr);
        int n = 0;
        awaddr = addr; awvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!awready && n < TIMEOUT);
        if (!awready) timeout("aw_handshake");
        @(posedge clk); #1; awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!wready && n < TIMEOUT);
        if (!wready) timeout("w_handshake");
        @(posedge clk); #1; wvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [5:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int n = 0;
        r_exp_q.push_back({exp_resp, exp_data});
        araddr = addr; arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!arready && n < TIMEOUT);
        if (!arready) timeout("ar_handshake");
        @(posedge clk); #1; arvalid = 1'b0;
    endtask

    task automatic wait_b();
        int n = 0;
        do begin @(negedge clk); n++; end while (!(bvalid && bready) && n < TIMEOUT);
        if (!(bvalid && bready)) timeout("b_handshake");
        @(posedge clk); #1;
    endtask

    task automatic wait_r();
        int n = 0;
        do begin @(negedge clk); n++; end while (!(rvalid && rready) && n < TIMEOUT);
        if (!(rvalid && rready)) timeout("r_handshake");
        @(posedge clk); #1;
    endtask

    task automatic axil_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input logic [1:0] exp_resp, input bit wait_resp);
        b_exp_q.push_back(exp_resp);
        fork
            aw_send(addr);
            w_send(data, strb);
        join
        if (wait_resp) wait_b();
    endtask

    task automatic axil_read(input logic [5:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        ar_send(addr, exp_data, exp_resp);
        wait_r();
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", {127'b0, awready}, 128'd0);
        check("rst_wready",  {127'b0, wready},  128'd0);
        check("rst_arready", {127'b0, arready}, 128'd0);
        check("rst_bvalid",  {127'b0, bvalid},  128'd0);
        check("rst_rvalid",  {127'b0, rvalid},  128'd0);
        check("rst_resp",    {124'b0, bresp, rresp}, 128'd0);
        check("rst_rdata",   {96'b0, rdata}, 128'd0);
        check("rst_regs",    regs_o, 128'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("ready_before_first_edge", {125'b0, awready, wready, arready}, 128'd0);
        @(posedge clk); #1;
        check("ready_after_first_edge", {125'b0, awready, wready, arready}, 128'd7);

        // 1: basic writes and readback
        for (int i = 0; i < 4; i++) axil_write(6'(4*i), 32'(i+1), 4'hF, 2'b00, 1'b1);
        check("regs_after_basic", regs_o, {32'd4, 32'd3, 32'd2, 32'd1});
        for (int i = 0; i < 4; i++) axil_read(6'(4*i), 32'(i+1), 2'b00);

        // 2: byte strobes
        axil_write(6'h04, 32'h1122_3344, 4'hF, 2'b00, 1'b1);
        axil_write(6'h04, 32'hAABB_CCDD, 4'b0101, 2'b00, 1'b1);
        axil_read(6'h04, 32'h11BB_33DD, 2'b00);

        // Collision: AR accepted on the commit edge sees the old value
        axil_write(6'h0C, 32'h77, 4'hF, 2'b00, 1'b0);
        ar_send(6'h0C, 32'd4, 2'b00);
        wait_b();
        axil_read(6'h0C, 32'h77, 2'b00);

        // 3: W three cycles ahead of AW, then AW ahead of W
        b_exp_q.push_back(2'b00);
        w_send(32'hA5A5, 4'hF);
        repeat (2) begin @(posedge clk); #1; end
        aw_send(6'h00);
        check("w_first_bvalid_at_hs", {127'b0, bvalid}, 128'd0);
        @(posedge clk); #1;
        check("w_first_bvalid_next", {127'b0, bvalid}, 128'd1);
        @(posedge clk); #1;
        b_exp_q.push_back(2'b00);
        aw_send(6'h08);
        repeat (2) begin @(posedge clk); #1; end
        w_send(32'h5A5A, 4'hF);
        check("aw_first_bvalid_at_hs", {127'b0, bvalid}, 128'd0);
        @(posedge clk); #1;
        check("aw_first_bvalid_next", {127'b0, bvalid}, 128'd1);
        @(posedge clk); #1;
        check("regs_after_order", regs_o, {32'h77, 32'h5A5A, 32'h11BB_33DD, 32'hA5A5});

        // 4: back-pressure on B then on R
        bready = 1'b0;
        axil_write(6'h04, 32'hCAFE, 4'hF, 2'b00, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bstall_bvalid", {127'b0, bvalid}, 128'd1);
            check("bstall_bresp", {126'b0, bresp}, 128'd0);
            check("bstall_readys", {126'b0, awready, wready}, 128'd0);
        end
        @(posedge clk); #1; bready = 1'b1;
        wait_b();
        rready = 1'b0;
        ar_send(6'h04, 32'hCAFE, 2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rstall_rvalid", {127'b0, rvalid}, 128'd1);
            check("rstall_rdata", {96'b0, rdata}, {96'b0, 32'hCAFE});
            check("rstall_arready", {127'b0, arready}, 128'd0);
        end
        @(posedge clk); #1; rready = 1'b1;
        wait_r();

        // 5: out-of-range slot
`ifdef QUSIM_AXIL_DECERR_EN
        axil_write(6'h10, 32'h55, 4'hF, 2'b10, 1'b1);
        check("oor_regs", regs_o, {32'h77, 32'h5A5A, 32'hCAFE, 32'hA5A5});
        axil_read(6'h10, 32'hDEAD_BEEF, 2'b10);
        axil_read(6'h00, 32'hA5A5, 2'b00);
`else
        axil_write(6'h10, 32'h55, 4'hF, 2'b00, 1'b1);
        check("oor_regs", regs_o, {32'h77, 32'h5A5A, 32'hCAFE, 32'h55});
        axil_read(6'h10, 32'h55, 2'b00);
`endif

        // 6: reset between AW and W discards the partial write
        aw_send(6'h00);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_regs", regs_o, 128'd0);
        check("midrst_bvalid", {127'b0, bvalid}, 128'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_low", {125'b0, awready, wready, arready}, 128'd0);
        @(posedge clk); #1;
        check("midrst_ready_high", {125'b0, awready, wready, arready}, 128'd7);
        axil_write(6'h08, 32'h1234, 4'hF, 2'b00, 1'b1);
        check("postrst_regs", regs_o, {32'h0, 32'h1234, 32'h0, 32'h0});
        axil_read(6'h08, 32'h1234, 2'b00);

        repeat (3) @(posedge clk);
        check("b_queue_drained", 128'(b_exp_q.size()), 128'd0);
        check("r_queue_drained", 128'(r_exp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
